cla_16bit: RTL and testbench
============================

// Module: cla_16bit
// PURPOSE
//   16-bit two-level carry-lookahead adder with a registered result.
//   Computes {cout,sum} = A + B + cin with no ripple carry between 4-bit slices.
//   Reusable datapath adder (ALU/accumulator front end), one result per clock.
// PARAMETERS
//   none. Width fixed at 16 bits, built as 4 slices of 4 bits.
// PORTS
//   clk    in   1   sole clock; all state updates on rising edge
//   reset  in   1   synchronous, active-high reset
//   A      in   16  operand A, unsigned
//   B      in   16  operand B, unsigned
//   cin    in   1   carry-in to bit 0
//   sum    out  16  registered sum bits [15:0]
//   cout   out  1   registered carry-out of bit 15
// BEHAVIOUR
//   - Clocking: one clock (clk). Reset is synchronous and active-high; sampled only on rising clk.
//   - Reset: while reset=1 at a rising edge, sum<=16'h0000 and cout<=0.
//     Reset wins over any operand values presented in the same cycle.
//   - Arithmetic: unsigned 17-bit result {cout,sum} = A + B + cin.
//     Overflow is reported only via cout; sum wraps modulo 2^16. No signed overflow flag.
//   - Latency: 1 cycle. Operands sampled at edge N appear on sum/cout after edge N.
//     New operands are accepted every cycle. No handshake, no stall.
//   - Outputs hold their value between edges.
//     After reset deasserts, the first edge loads the result of the operands present at that edge.
//   - Structure, combinational core:
//     * bit level: p[i]=A[i]^B[i], g[i]=A[i]&B[i], sum[i]=p[i]^c[i].
//     * 4-bit slice: internal carries c1..c3 from c0 by flattened lookahead equations.
//       Each slice also exports group PG=&p[3:0] and GG=g3|p3g2|p3p2g1|p3p2p1g0.
//     * lookahead unit computes c4, c8, c12, c16 directly from cin and the slice PG/GG.
//       Flattened equations only, no slice-to-slice ripple. cout = c16.
//   - Core is purely combinational, with no latches.
//     Only the 17 output flops hold state; inputs are not registered.
//   - X/Z on inputs is not handled. Operands are assumed driven whenever reset=0.
// TESTING
//   - Reset: reset=1 for 2 edges with A=FFFF, B=FFFF, cin=1 -> sum=0000, cout=0.
//   - Basic: 0000+0000+0 -> 0000/0; 0001+0000+0 -> 0001/0 (one cycle later).
//   - All-propagate chains:
//     * 0F0F+F0F0+0 -> FFFF/0.
//     * FF00+00FF+1 -> 0000/1 (cin propagates through all 16 bits).
//     * FFFF+000F+0 -> 000E/1.
//   - Mixed carries:
//     * FFF0+0FF0+0 -> 0FE0/1.
//     * 000F+FF00+1 -> FF10/0.
//     * FF00+0FF0+0 -> 0EF0/1.
//     * 0FFF+0F00+1 -> 1F00/0.
//   - Back-to-back operands on consecutive edges produce results on consecutive cycles.
//     Reset asserted mid-stream clears the outputs on that edge.
//     Results resume on the first edge after reset is released.
//   - Randomized: at least 10k random A/B/cin vectors checked against a behavioural A+B+cin model.
//     Bench must also cover cin=1 with A+B=FFFF, where cout=1 and sum=0000.

Source files
------------

// File: rtl/cla_16bit_if.sv
// rtl/cla_16bit_if.sv - operand/result bundle for the 16-bit lookahead adder
interface cla_16bit_if;
  logic [15:0] A;
  logic [15:0] B;
  logic        cin;
  logic [15:0] sum;
  logic        cout;

  modport master (output A, output B, output cin, input sum, input cout);
  modport slave  (input A, input B, input cin, output sum, output cout);
endinterface

// File: rtl/cla_16bit.sv
// rtl/cla_16bit.sv - 16-bit two-level carry-lookahead adder with registered result
module cla_16bit (
  input logic        clk,
  input logic        reset,
  cla_16bit_if.slave bus
);

  logic [15:0] p;
  logic [15:0] g;
  logic [15:0] sum_c;
  logic [3:0]  pg;
  logic [3:0]  gg;
  logic [4:0]  cg;

  assign p = bus.A ^ bus.B;
  assign g = bus.A & bus.B;

  for (genvar s = 0; s < 4; s++) begin : g_slice
    logic [3:0] sp;
    logic [3:0] sg;
    logic [3:0] sc;

    assign sp    = p[4*s +: 4];
    assign sg    = g[4*s +: 4];
    assign sc[0] = cg[s];
    assign sc[1] = sg[0] | (sp[0] & sc[0]);
    assign sc[2] = sg[1] | (sp[1] & sg[0]) | (sp[1] & sp[0] & sc[0]);
    assign sc[3] = sg[2] | (sp[2] & sg[1]) | (sp[2] & sp[1] & sg[0])
                 | (sp[2] & sp[1] & sp[0] & sc[0]);

    assign pg[s] = &sp;
    assign gg[s] = sg[3] | (sp[3] & sg[2]) | (sp[3] & sp[2] & sg[1])
                 | (sp[3] & sp[2] & sp[1] & sg[0]);

    assign sum_c[4*s +: 4] = sp ^ sc;
  end

  // Second-level lookahead: every slice carry-in comes straight from cin.
  assign cg[0] = bus.cin;
  assign cg[1] = gg[0] | (pg[0] & bus.cin);
  assign cg[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & bus.cin);
  assign cg[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
               | (pg[2] & pg[1] & pg[0] & bus.cin);
  assign cg[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
               | (pg[3] & pg[2] & pg[1] & gg[0])
               | (pg[3] & pg[2] & pg[1] & pg[0] & bus.cin);

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.sum  <= 16'h0000;
      bus.cout <= 1'b0;
    end else begin
      bus.sum  <= sum_c;
      bus.cout <= cg[4];
    end
  end

endmodule

// File: tb/tb_cla_16bit.sv
// tb/tb_cla_16bit.sv - randomized self-checking bench for cla_16bit
module tb_cla_16bit;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  cla_16bit_if bus ();

  cla_16bit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic c);
    return {1'b0, a} + {1'b0, b} + {16'd0, c};
  endfunction

  task automatic test_reset();
    reset   = 1'b1;
    bus.A   = 16'hFFFF;
    bus.B   = 16'hFFFF;
    bus.cin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({bus.cout, bus.sum} !== 17'h00000) begin
      fails++;
      $display("FAIL reset: got %h/%b want 0000/0", bus.sum, bus.cout);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Table-driven directed vectors, one operand set per edge, checked after that edge.
  task automatic test_directed();
    logic [15:0] ta [11];
    logic [15:0] tb [11];
    logic        tc [11];
    logic [16:0] want [11];
    ta = '{16'h0000, 16'h0001, 16'h0F0F, 16'hFF00, 16'hFFFF, 16'hFFF0,
           16'h000F, 16'hFF00, 16'h0FFF, 16'h1234, 16'h8000};
    tb = '{16'h0000, 16'h0000, 16'hF0F0, 16'h00FF, 16'h000F, 16'h0FF0,
           16'hFF00, 16'h0FF0, 16'h0F00, 16'hEDCB, 16'h8000};
    tc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    want = '{17'h00000, 17'h00001, 17'h0FFFF, 17'h10000, 17'h1000E, 17'h10FE0,
             17'h0FF10, 17'h10EF0, 17'h01F00, 17'h10000, 17'h10000};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      bus.A = ta[i]; bus.B = tb[i]; bus.cin = tc[i];
      @(posedge clk);
      #1;
      tests++;
      if ({bus.cout, bus.sum} !== want[i]) begin
        fails++;
        $display("FAIL directed[%0d]: got %h/%b want %h/%b", i, bus.sum, bus.cout,
                 want[i][15:0], want[i][16]);
      end
    end
  endtask

  task automatic test_hold();
    logic [16:0] held;
    @(negedge clk);
    bus.A = 16'h4321; bus.B = 16'h1111; bus.cin = 1'b1;
    @(posedge clk);
    #1;
    held = model(16'h4321, 16'h1111, 1'b1);
    bus.A = 16'hAAAA; bus.B = 16'h5555; bus.cin = 1'b1;
    #3;
    tests++;
    if ({bus.cout, bus.sum} !== held) begin
      fails++;
      $display("FAIL hold: got %h/%b want %h/%b", bus.sum, bus.cout, held[15:0], held[16]);
    end
  endtask

  // Drives new operands every negedge and checks the previous edge's result on the way.
  task automatic test_back_to_back();
    logic [16:0] exp_q [$];
    logic [16:0] want;
    logic [15:0] a, b;
    logic        c;
    exp_q = {};
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        tests++;
        if ({bus.cout, bus.sum} !== want) begin
          fails++;
          $display("FAIL back_to_back[%0d]: got %h/%b want %h/%b", i, bus.sum, bus.cout,
                   want[15:0], want[16]);
        end
      end
      a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
      bus.A = a; bus.B = b; bus.cin = c;
      reset = (i == 10 || i == 11);
      exp_q.push_back(reset ? 17'h00000 : model(a, b, c));
    end
    @(negedge clk);
    want = exp_q.pop_front();
    tests++;
    if ({bus.cout, bus.sum} !== want) begin
      fails++;
      $display("FAIL back_to_back_last: got %h/%b want %h/%b", bus.sum, bus.cout,
               want[15:0], want[16]);
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic [16:0] want;
    logic [15:0] a, b;
    logic        c;
    int          bad;
    bad = 0;
    for (int i = 0; i < 10500; i++) begin
      a = 16'($urandom);
      if (i % 20 == 0) begin
        b = ~a; c = 1'b1;
      end else begin
        b = 16'($urandom); c = 1'($urandom);
      end
      @(negedge clk);
      bus.A = a; bus.B = b; bus.cin = c;
      @(posedge clk);
      #1;
      want = model(a, b, c);
      tests++;
      if ({bus.cout, bus.sum} !== want) begin
        fails++;
        bad++;
        if (bad <= 10)
          $display("FAIL random: %h+%h+%b got %h/%b want %h/%b", a, b, c, bus.sum,
                   bus.cout, want[15:0], want[16]);
      end
    end
  endtask

  task automatic test_propagate_all();
    logic [15:0] a;
    for (int i = 0; i < 16; i++) begin
      a = 16'($urandom);
      @(negedge clk);
      bus.A = a; bus.B = ~a; bus.cin = 1'b1;
      @(posedge clk);
      #1;
      tests++;
      if ({bus.cout, bus.sum} !== 17'h10000) begin
        fails++;
        $display("FAIL propagate_all: %h+%h+1 got %h/%b want 0000/1", a, ~a, bus.sum,
                 bus.cout);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    bus.A = 16'h0000; bus.B = 16'h0000; bus.cin = 1'b0;
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    test_propagate_all();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
